// File: rtl/alu_issue_stage.sv
// Execute-issue stage: forwards operands, detects load-use hazards and decodes the ALU select.
// Results are held in a single-entry valid/ready buffer that drives the ALU inputs.
module alu_issue_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              exm_we,
    input  logic              exm_is_load,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              mwb_we,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [XLEN-1:0]   mwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        ALU_Sel,
    output logic [XLEN-1:0]   tmpA,
    output logic [XLEN-1:0]   tmpB,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal,
    output logic              hazard_stall
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1001;
    localparam logic [3:0] AluSltu = 4'b1010;
    localparam logic [3:0] AluNop  = 4'b1111;

    function automatic logic [3:0] f3_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        unique case (f3)
            3'b000:  sel = alt ? AluSub : AluAdd;
            3'b001:  sel = AluSll;
            3'b010:  sel = AluSlt;
            3'b011:  sel = AluSltu;
            3'b100:  sel = AluXor;
            3'b101:  sel = alt ? AluSra : AluSrl;
            3'b110:  sel = AluOr;
            default: sel = AluAnd;
        endcase
        return sel;
    endfunction

    // Loads in EX/MEM have no data yet; those cases are covered by the stall instead.
    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_val,
        input logic              e_we,
        input logic              e_load,
        input logic [REG_AW-1:0] e_rd,
        input logic [XLEN-1:0]   e_data,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd,
        input logic [XLEN-1:0]   w_data
    );
        logic [XLEN-1:0] val;
        if (rs == '0) begin
            val = '0;
        end else if (e_we && (e_rd == rs) && !e_load) begin
            val = e_data;
        end else if (w_we && (w_rd == rs)) begin
            val = w_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            uses_rs1, uses_rs2;
    logic            accept;

    logic [3:0]        sel_d, sel_q;
    logic [XLEN-1:0]   a_d, a_q, b_d, b_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              ill_d, ill_q;
    logic              valid_q;
    logic              is_shift;

    assign rs1_fwd = fwd(in_rs1, in_rs1_val, exm_we, exm_is_load, exm_rd, exm_data,
                         mwb_we, mwb_rd, mwb_data);
    assign rs2_fwd = fwd(in_rs2, in_rs2_val, exm_we, exm_is_load, exm_rd, exm_data,
                         mwb_we, mwb_rd, mwb_data);

    always_comb begin
        uses_rs1 = !((in_opcode == OpcLui) || (in_opcode == OpcAuipc) || (in_opcode == OpcJal));
        uses_rs2 = (in_opcode == OpcOp) || (in_opcode == OpcBranch) || (in_opcode == OpcStore);
        hazard_stall = in_valid && exm_we && exm_is_load && (exm_rd != '0) &&
                       ((uses_rs1 && (exm_rd == in_rs1)) || (uses_rs2 && (exm_rd == in_rs2)));
    end

    assign in_ready = (!valid_q || out_ready) && !hazard_stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sel_d    = AluAdd;
        a_d      = '0;
        b_d      = '0;
        rd_d     = in_rd;
        ill_d    = 1'b0;
        is_shift = 1'b0;
        case (in_opcode)
            OpcOp: begin
                sel_d    = f3_sel(in_funct3, in_funct7b5);
                a_d      = rs1_fwd;
                b_d      = rs2_fwd;
                is_shift = (in_funct3[1:0] == 2'b01);
            end
            OpcOpImm: begin
                sel_d    = f3_sel(in_funct3, in_funct7b5 && (in_funct3 == 3'b101));
                a_d      = rs1_fwd;
                b_d      = in_imm;
                is_shift = (in_funct3[1:0] == 2'b01);
            end
            OpcLui: begin
                b_d = in_imm;
            end
            OpcAuipc: begin
                a_d = in_pc;
                b_d = in_imm;
            end
            OpcLoad: begin
                a_d = rs1_fwd;
                b_d = in_imm;
            end
            OpcStore: begin
                a_d  = rs1_fwd;
                b_d  = in_imm;
                rd_d = '0;
            end
            OpcBranch: begin
                a_d  = rs1_fwd;
                b_d  = rs2_fwd;
                rd_d = '0;
                case (in_funct3[2:1])
                    2'b00:   sel_d = AluSub;
                    2'b10:   sel_d = AluSlt;
                    2'b11:   sel_d = AluSltu;
                    default: ill_d = 1'b1;
                endcase
            end
            OpcJal, OpcJalr: begin
                a_d = in_pc;
                b_d = XLEN'(4);
            end
            default: ill_d = 1'b1;
        endcase
        // The ALU shifts by the whole operand, so trim the amount to 5 bits here.
        if (is_shift) begin
            b_d = {{(XLEN-5){1'b0}}, b_d[4:0]};
        end
        if (ill_d) begin
            sel_d = AluNop;
            a_d   = '0;
            b_d   = '0;
            rd_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= 4'b0000;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign ALU_Sel     = sel_q;
    assign tmpA        = a_q;
    assign tmpB        = b_q;
    assign out_rd      = rd_q;
    assign out_illegal = ill_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the ALU.
- Takes one decoded RV32I instruction from ID, forwards operands from later stages, and generates the ALU selection code.
- Registers ALU_Sel, tmpA and tmpB into a single-entry output buffer that drives the ALU inputs, with valid/ready handshakes on both sides.
- Also detects load-use hazards and stalls ID.

Parameters:
XLEN, 32, datapath width; the only supported value is 32.
REG_AW, 5, register index width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  ID presents an instruction.
in_ready  out  1  stage accepts the instruction this cycle.
in_opcode  in  7  instr[6:0].
in_funct3  in  3  instr[14:12].
in_funct7b5  in  1  instr[30].
in_rs1, in_rs2  in  REG_AW  source indices.
in_rd  in  REG_AW  destination index.
in_rs1_val, in_rs2_val  in  XLEN  register-file read data.
in_imm  in  XLEN  sign-extended immediate, already formatted for the instruction type.
in_pc  in  XLEN  instruction PC.
exm_we, exm_is_load  in  1  EX/MEM stage writes rd / is a load.
exm_rd  in  REG_AW; exm_data  in  XLEN  EX/MEM result.
mwb_we  in  1; mwb_rd  in  REG_AW; mwb_data  in  XLEN  MEM/WB result.
out_valid  out  1  ALU operands valid.
out_ready  in  1  downstream consumes this cycle.
ALU_Sel  out  4  ALU operation code.
tmpA, tmpB  out  XLEN  ALU operands.
out_rd  out  REG_AW  destination index carried alongside.
out_illegal  out  1  unsupported opcode/funct.
hazard_stall  out  1  load-use stall indicator.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, ALU_Sel=4'b0000, tmpA=0, tmpB=0, out_rd=0, out_illegal=0.
- The combinational outputs in_ready and hazard_stall follow their equations regardless of reset.
- Release of rst_n is synchronous to clk.
- Reset mid-transfer discards the buffered entry.
- Buffer: in_ready = (!out_valid | out_ready) & !hazard_stall.
- Accept when in_valid & in_ready; the registered outputs update on that edge, giving one cycle of latency.
- If out_valid & !out_ready, all outputs hold stable.
- If out_ready & !accept, out_valid falls to 0.
- Simultaneous consume and accept gives back-to-back throughput of one per cycle.
- Operand forwarding, per source rs1 and rs2:
  - Index 0 always reads 0, with no forwarding.
  - Otherwise, if exm_we & exm_rd==rs & !exm_is_load, use exm_data.
  - Else if mwb_we & mwb_rd==rs, use mwb_data.
  - Else use the register-file value.
  - EX/MEM has priority over MEM/WB.
- hazard_stall = in_valid & exm_we & exm_is_load & exm_rd!=0 & exm_rd matches a source the instruction actually uses.
  - rs2 is used only by R-type, branch and store.
  - rs1 is not used by LUI, AUIPC or JAL.
- Decode, giving ALU_Sel / tmpA / tmpB:
  - OP 0110011: funct3 000 → add (0000), or sub (0001) if funct7b5. 111 → 0010, 110 → 0011, 100 → 0100, 001 → 0101, 101 → 0110, or 0111 if funct7b5. 010 → 1001, 011 → 1010. Operands A=rs1, B=rs2.
  - OP-IMM 0010011: same mapping, but funct3 000 is always add, and funct7b5 is honoured only for 101. Operands A=rs1, B=imm.
  - Shifts (both OP and OP-IMM): tmpB = zero-extended B[4:0]. This is mandatory because the ALU shifts by the full 32-bit operand.
  - LUI 0110111: add, A=0, B=imm.
  - AUIPC 0010111: add, A=pc, B=imm.
  - LOAD 0000011 / STORE 0100011: add, A=rs1, B=imm.
  - BRANCH 1100011: funct3 00x → sub; 10x → 1001; 11x → 1010; 01x is illegal. Operands A=rs1, B=rs2.
  - JAL 1101111 / JALR 1100111: add, A=pc, B=32'd4.
  - Any other opcode, or illegal funct: ALU_Sel=4'b1111 (the ALU yields 0), tmpA=tmpB=0, out_illegal=1.
- out_rd is 0 for BRANCH, STORE and illegal instructions; otherwise it is in_rd.

Test Plan:
- Reset: rst_n=0 asserted mid-stream while out_valid=1 → outputs go to 0 immediately without a clock edge; after release, in_ready=1.
- Decode: `sub x3,x1,x2` with rs1_val=10, rs2_val=3 → next cycle ALU_Sel=0001, tmpA=10, tmpB=3, out_rd=3.
- Decode: `srai x5,x6,4` with rs6=0x80000000 and imm=0x404 → ALU_Sel=0111, tmpB=4.
- Decode: `auipc` with pc=0x100, imm=0x2000 → 0000, tmpA=0x100, tmpB=0x2000.
- Forwarding: rs1=7, rs2=7 with exm_we=1, exm_rd=7, exm_data=0xAA and mwb_we=1, mwb_rd=7, mwb_data=0xBB → both operands take 0xAA. Repeat with rs=0 → operands are 0.
- Load-use: exm_is_load=1, exm_rd=4, in_rs2=4 on an R-type → hazard_stall=1, in_ready=0, no accept. Same case on OP-IMM → no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid held → outputs stable, in_ready=0. Then out_ready=1 → the new instruction loads on the same edge and out_valid stays 1.
- Illegal: opcode 0x7F → ALU_Sel=1111, tmpA=tmpB=0, out_illegal=1.
